// File: rtl/io_entry_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_entry_pkg                                                         |
// | State, mode codes and sizing helpers for the front-panel controller. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package io_entry_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        CLR_SEL    = 4'd1,
        WR_SEL     = 4'd2,
        RD_SEL     = 4'd3,
        ADDR_ENTRY = 4'd4,
        DATA_ENTRY = 4'd5,
        ISSUE      = 4'd6,
        SHOW       = 4'd7,
        CLEARING   = 4'd8
    } state_t;

    localparam logic [1:0] c_MODE_CLR  = 2'b00;
    localparam logic [1:0] c_MODE_RD   = 2'b01;
    localparam logic [1:0] c_MODE_WR   = 2'b10;
    localparam logic [1:0] c_MODE_IDLE = 2'b11;

    function automatic int ceilDiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_entry_ctrl_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_sync                                                            |
// | Two-flop synchronizer followed by a one-cycle rising-edge pulse.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);

    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], i_async};
        end
    end

    assign o_pulse = r_sync[1] & ~r_sync[2];

endmodule
`default_nettype wire

// File: rtl/io_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_entry_ctrl                                                        |
// | Key/switch driven entry of memory read, write and clear operations.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module io_entry_ctrl
    import io_entry_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int NSW       = 4,
    parameter int CLR_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key0,
    input  logic                key1,
    input  logic [NSW-1:0]      sw,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [1:0]          mode,
    output logic [3:0]          stage,
    output logic [4*NSW-1:0]    display,
    output logic                busy,
    output logic                done
);

    localparam int c_AD     = ceilDiv(ADDR_W, 4);
    localparam int c_DD     = ceilDiv(DATA_W, 4);
    localparam int c_AP     = ceilDiv(c_AD, NSW);
    localparam int c_DP     = ceilDiv(c_DD, NSW);
    localparam int c_ATOP_W = ADDR_W - 4 * (c_AD - 1);
    localparam int c_DTOP_W = DATA_W - 4 * (c_DD - 1);
    localparam logic [3:0]        c_AP_LAST  = 4'(c_AP - 1);
    localparam logic [3:0]        c_DP_LAST  = 4'(c_DP - 1);
    localparam logic [ADDR_W-1:0] c_CLR_LAST = ADDR_W'(CLR_WORDS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_page;
    logic                r_isWrite;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addrOut;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_result;
    logic [ADDR_W-1:0]   r_clrCnt;
    logic                r_done;

    logic                w_key0Ev;
    logic                w_key1Raw;
    logic                w_key1Ev;
    logic [NSW-1:0]      w_swEv;
    logic                w_lastPage;
    logic [4*c_AD-1:0]   w_addrDig;
    logic [4*c_DD-1:0]   w_dataDig;
    logic [4*NSW*c_AP-1:0] w_addrPad;
    logic [4*NSW*c_DP-1:0] w_dataPad;
    logic [4*NSW*c_DP-1:0] w_resPad;

    edge_sync u_key0Sync (.clk(clk), .rst(rst), .i_async(key0), .o_pulse(w_key0Ev));
    edge_sync u_key1Sync (.clk(clk), .rst(rst), .i_async(key1), .o_pulse(w_key1Raw));

    generate
        for (genvar i = 0; i < NSW; i++) begin : g_swSync
            edge_sync u_swSync (.clk(clk), .rst(rst), .i_async(sw[i]), .o_pulse(w_swEv[i]));
        end
    endgenerate

    // key0 has priority whenever both keys fire together
    assign w_key1Ev = w_key1Raw & ~w_key0Ev;

    // Each digit counts modulo 16, except the top one which only spans the remaining bits
    generate
        for (genvar k = 0; k < c_AD; k++) begin : g_addrDig
            localparam logic [3:0] c_MASK = (k == c_AD - 1) ? 4'((1 << c_ATOP_W) - 1) : 4'hF;
            logic [3:0] r_dig;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dig <= 4'h0;
                end else if (r_state == ADDR_ENTRY && r_page == 4'(k / NSW) && w_swEv[k % NSW]) begin
                    r_dig <= (r_dig + 4'h1) & c_MASK;
                end
            end
            assign w_addrDig[4*k +: 4] = r_dig;
        end
        for (genvar k = 0; k < c_DD; k++) begin : g_dataDig
            localparam logic [3:0] c_MASK = (k == c_DD - 1) ? 4'((1 << c_DTOP_W) - 1) : 4'hF;
            logic [3:0] r_dig;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dig <= 4'h0;
                end else if (r_state == DATA_ENTRY && r_page == 4'(k / NSW) && w_swEv[k % NSW]) begin
                    r_dig <= (r_dig + 4'h1) & c_MASK;
                end
            end
            assign w_dataDig[4*k +: 4] = r_dig;
        end
    endgenerate

    always_comb begin
        w_lastPage = 1'b1;
        if (r_state == ADDR_ENTRY) begin
            w_lastPage = (r_page == c_AP_LAST);
        end else if (r_state == DATA_ENTRY || r_state == SHOW) begin
            w_lastPage = (r_page == c_DP_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_key0Ev) w_next = CLR_SEL;
            CLR_SEL:    if (w_key0Ev) w_next = WR_SEL;
                        else if (w_key1Ev) w_next = CLEARING;
            WR_SEL:     if (w_key0Ev) w_next = RD_SEL;
                        else if (w_key1Ev) w_next = ADDR_ENTRY;
            RD_SEL:     if (w_key0Ev) w_next = CLR_SEL;
                        else if (w_key1Ev) w_next = ADDR_ENTRY;
            ADDR_ENTRY: if (w_key1Ev && w_lastPage) w_next = r_isWrite ? DATA_ENTRY : ISSUE;
            DATA_ENTRY: if (w_key1Ev && w_lastPage) w_next = ISSUE;
            ISSUE:      if (mem_ack) w_next = r_isWrite ? IDLE : SHOW;
            SHOW:       if (w_key1Ev && w_lastPage) w_next = IDLE;
            CLEARING:   if (r_req && mem_ack && r_clrCnt == c_CLR_LAST) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_page    <= 4'd0;
            r_isWrite <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addrOut <= '0;
            r_wdata   <= '0;
            r_result  <= '0;
            r_clrCnt  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                CLR_SEL: begin
                    if (w_next == CLEARING) begin
                        r_clrCnt  <= '0;
                        r_req     <= 1'b1;
                        r_we      <= 1'b1;
                        r_addrOut <= '0;
                        r_wdata   <= '0;
                    end
                end
                WR_SEL, RD_SEL: begin
                    if (w_next == ADDR_ENTRY) begin
                        r_page    <= 4'd0;
                        r_isWrite <= (r_state == WR_SEL);
                    end
                end
                ADDR_ENTRY, DATA_ENTRY, SHOW: begin
                    if (w_key1Ev) begin
                        r_page <= w_lastPage ? 4'd0 : r_page + 4'd1;
                    end
                    if (w_next == ISSUE) begin
                        r_req     <= 1'b1;
                        r_we      <= r_isWrite;
                        r_addrOut <= w_addrDig[ADDR_W-1:0];
                        r_wdata   <= w_dataDig[DATA_W-1:0];
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        r_req  <= 1'b0;
                        r_done <= 1'b1;
                        if (!r_isWrite) begin
                            r_result <= mem_rdata;
                        end
                    end
                end
                CLEARING: begin
                    // Each word drops req for one cycle after its ack before the next word
                    if (r_req) begin
                        if (mem_ack) begin
                            r_req <= 1'b0;
                            if (r_clrCnt == c_CLR_LAST) begin
                                r_done <= 1'b1;
                            end else begin
                                r_clrCnt <= r_clrCnt + 1'b1;
                            end
                        end
                    end else begin
                        r_req     <= 1'b1;
                        r_addrOut <= r_clrCnt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mode  = c_MODE_IDLE;
        stage = 4'd0;
        case (r_state)
            CLR_SEL, CLEARING:  mode = c_MODE_CLR;
            WR_SEL:             mode = c_MODE_WR;
            RD_SEL, SHOW:       mode = c_MODE_RD;
            ADDR_ENTRY, DATA_ENTRY: begin
                mode  = r_isWrite ? c_MODE_WR : c_MODE_RD;
                stage = r_page + 4'd1;
            end
            ISSUE:              mode = r_isWrite ? c_MODE_WR : c_MODE_RD;
            default:            mode = c_MODE_IDLE;
        endcase
    end

    always_comb begin
        w_addrPad = '0;
        w_addrPad[4*c_AD-1:0] = w_addrDig;
        w_dataPad = '0;
        w_dataPad[4*c_DD-1:0] = w_dataDig;
        w_resPad = '0;
        w_resPad[DATA_W-1:0] = r_result;
        display = '0;
        for (int p = 0; p < c_AP; p++) begin
            if (r_state == ADDR_ENTRY && r_page == 4'(p)) display = w_addrPad[p*4*NSW +: 4*NSW];
        end
        for (int p = 0; p < c_DP; p++) begin
            if (r_state == DATA_ENTRY && r_page == 4'(p)) display = w_dataPad[p*4*NSW +: 4*NSW];
            if (r_state == SHOW && r_page == 4'(p))       display = w_resPad[p*4*NSW +: 4*NSW];
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addrOut;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state == ISSUE) || (r_state == CLEARING);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_io_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_io_entry_ctrl                                                     |
// | Directed scoreboard bench for the front-panel entry controller.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_io_entry_ctrl;

    localparam int ADDR_W    = 25;
    localparam int DATA_W    = 16;
    localparam int NSW       = 4;
    localparam int CLR_WORDS = 4;
    localparam int K0        = NSW;
    localparam int K1        = NSW + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              key0;
    logic              key1;
    logic [NSW-1:0]    sw;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mode;
    logic [3:0]        stage;
    logic [4*NSW-1:0]  display;
    logic              busy;
    logic              done;

    int   checks = 0;
    int   errors = 0;
    txn_t expQ[$];
    logic [DATA_W-1:0] memModel [int];
    int   ackDelay = 0;
    int   waitCnt = 0;
    int   reqCycles = 0;
    int   lastReqCycles = 0;
    int   doneCnt = 0;

    always #5 clk = ~clk;

    io_entry_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSW(NSW), .CLR_WORDS(CLR_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .key0(key0), .key1(key1), .sw(sw),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mode(mode), .stage(stage), .display(display), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mkTxn(input logic we, input logic [ADDR_W-1:0] addr,
                                   input logic [DATA_W-1:0] wdata);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.wdata = wdata;
        return t;
    endfunction

    task automatic drive(input int idx, input logic v);
        if (idx < NSW) sw[idx] = v;
        else if (idx == K0) key0 = v;
        else key1 = v;
    endtask

    task automatic press(input int idx, input int hold);
        drive(idx, 1'b1);
        repeat (hold) @(negedge clk);
        drive(idx, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic waitDone(input string tag, input int target, input int limit);
        int n = 0;
        while (doneCnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, 32'(doneCnt), 32'(target));
    endtask

    // Memory responder: acks after ackDelay waiting cycles and scores each transaction
    initial begin
        txn_t t;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (done) doneCnt++;
            if (rst) begin
                mem_ack = 1'b0;
                waitCnt = 0;
                reqCycles = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                reqCycles++;
                if (expQ.size() > 0) check("addr_stable", 32'(mem_addr), 32'(expQ[0].addr));
                if (waitCnt >= ackDelay) begin
                    check("txn_expected", 32'(expQ.size() > 0), 32'd1);
                    if (expQ.size() > 0) begin
                        t = expQ.pop_front();
                        check("txn_we", 32'(mem_we), 32'(t.we));
                        check("txn_addr", 32'(mem_addr), 32'(t.addr));
                        if (t.we) check("txn_wdata", 32'(mem_wdata), 32'(t.wdata));
                    end
                    if (mem_we) begin
                        memModel[int'(mem_addr)] = mem_wdata;
                    end else begin
                        mem_rdata = memModel.exists(int'(mem_addr)) ? memModel[int'(mem_addr)] : '0;
                    end
                    mem_ack = 1'b1;
                    waitCnt = 0;
                    lastReqCycles = reqCycles;
                    reqCycles = 0;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst = 1'b1;
        key0 = 1'b0;
        key1 = 1'b0;
        sw = '0;
        repeat (3) @(negedge clk);
        check("rst_mode", 32'(mode), 32'h3);
        check("rst_stage", 32'(stage), 32'h0);
        check("rst_display", 32'(display), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Write 0x00A5 to 0x0011003
        press(K0, 3);
        check("clr_sel_mode", 32'(mode), 32'h0);
        press(K0, 3);
        check("wr_sel_mode", 32'(mode), 32'h2);
        press(K1, 3);
        check("wr_addr_stage0", 32'(stage), 32'h1);
        check("wr_addr_mode", 32'(mode), 32'h2);
        repeat (3) press(0, 3);
        press(3, 3);
        check("addr_page0", 32'(display), 32'h1003);
        press(K1, 3);
        check("wr_addr_stage1", 32'(stage), 32'h2);
        check("addr_page1_init", 32'(display), 32'h0000);
        repeat (17) press(0, 3);
        check("addr_digit_mod16", 32'(display), 32'h0001);
        press(2, 3);
        check("top_digit_one", 32'(display), 32'h0101);
        press(2, 3);
        check("top_digit_wrap", 32'(display), 32'h0001);
        press(K1, 3);
        check("data_stage", 32'(stage), 32'h1);
        check("data_init", 32'(display), 32'h0000);
        repeat (5) press(0, 3);
        repeat (9) press(1, 3);
        check("data_partial", 32'(display), 32'h0095);
        press(1, 50);
        check("data_held_once", 32'(display), 32'h00A5);
        expQ.push_back(mkTxn(1'b1, 25'h0011003, 16'h00A5));
        ackDelay = 0;
        d = doneCnt;
        press(K1, 3);
        waitDone("wr_done", d + 1, 50);
        repeat (5) @(negedge clk);
        check("wr_done_once", 32'(doneCnt), 32'(d + 1));
        check("wr_queue_empty", 32'(expQ.size()), 32'h0);
        check("wr_idle_mode", 32'(mode), 32'h3);
        check("wr_busy_low", 32'(busy), 32'h0);

        // Read back with a delayed ack
        press(K0, 3);
        press(K0, 3);
        press(K0, 3);
        check("rd_sel_mode", 32'(mode), 32'h1);
        press(K1, 3);
        check("rd_addr_persist", 32'(display), 32'h1003);
        press(K1, 3);
        check("rd_addr_page1", 32'(display), 32'h0001);
        expQ.push_back(mkTxn(1'b0, 25'h0011003, 16'h0000));
        ackDelay = 5;
        d = doneCnt;
        press(K1, 3);
        check("rd_busy", 32'(busy), 32'h1);
        check("rd_req_held", 32'(mem_req), 32'h1);
        waitDone("rd_done", d + 1, 50);
        check("rd_req_cycles", 32'(lastReqCycles), 32'd6);
        check("show_mode", 32'(mode), 32'h1);
        check("show_stage", 32'(stage), 32'h0);
        check("show_display", 32'(display), 32'h00A5);
        check("rd_busy_low", 32'(busy), 32'h0);
        press(K1, 3);
        check("show_exit_mode", 32'(mode), 32'h3);
        check("show_exit_display", 32'(display), 32'h0);

        // key0 and key1 together in WR_SEL
        press(K0, 3);
        press(K0, 3);
        check("simul_pre_mode", 32'(mode), 32'h2);
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (3) @(negedge clk);
        key0 = 1'b0;
        key1 = 1'b0;
        repeat (4) @(negedge clk);
        check("simul_mode", 32'(mode), 32'h1);
        check("simul_stage", 32'(stage), 32'h0);

        // Clear four words
        press(K0, 3);
        check("clr_mode", 32'(mode), 32'h0);
        for (int a = 0; a < CLR_WORDS; a++) expQ.push_back(mkTxn(1'b1, ADDR_W'(a), 16'h0000));
        ackDelay = 0;
        d = doneCnt;
        press(K1, 3);
        waitDone("clr_done", d + 1, 100);
        repeat (5) @(negedge clk);
        check("clr_done_once", 32'(doneCnt), 32'(d + 1));
        check("clr_queue_empty", 32'(expQ.size()), 32'h0);
        check("clr_busy_low", 32'(busy), 32'h0);
        check("clr_idle_mode", 32'(mode), 32'h3);

        // Reset while waiting for an ack
        press(K0, 3);
        press(K0, 3);
        press(K0, 3);
        press(K1, 3);
        press(K1, 3);
        ackDelay = 1000;
        press(K1, 3);
        check("wait_req_high", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wait_req", 32'(mem_req), 32'h0);
        check("rst_wait_mode", 32'(mode), 32'h3);
        check("rst_wait_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
